// File: rtl/mr_idecode.sv
// RV32I decode stage: registers a decoded bundle for execute behind a valid/ready handshake.
// Define MR_ID_SKID_EN to add a one-entry skid buffer and a registered id_ready.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef IMAXLEN
`define IMAXLEN 32
`endif

module mr_idecode #(
  parameter int XLEN    = `XLEN,
  parameter int IMAXLEN = `IMAXLEN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IMAXLEN-1:0] inst,
  input  logic [XLEN-1:0]    inst_pc,
  input  logic               inst_valid,
  output logic               id_ready,
  input  logic               wb_pc_valid,
  output logic               ex_valid,
  input  logic               ex_ready,
  output logic [XLEN-1:0]    ex_pc,
  output logic [3:0]         ex_op,
  output logic [4:0]         ex_rd,
  output logic [4:0]         ex_rs1,
  output logic [4:0]         ex_rs2,
  output logic [XLEN-1:0]    ex_imm,
  output logic [2:0]         ex_funct3,
  output logic               ex_funct7b5,
  output logic               ex_illegal
);

  typedef enum logic [3:0] {
    OP_LUI = 4'd0, OP_AUIPC = 4'd1, OP_JAL = 4'd2, OP_JALR = 4'd3,
    OP_BRANCH = 4'd4, OP_LOAD = 4'd5, OP_STORE = 4'd6, OP_OPIMM = 4'd7,
    OP_OP = 4'd8, OP_FENCE = 4'd9, OP_SYSTEM = 4'd10, OP_ILLEGAL = 4'd15
  } op_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [3:0]      op;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            illegal;
  } bundle_t;

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic            legal;
  bundle_t         dec;

  assign f3    = inst[14:12];
  assign f7    = inst[31:25];
  assign imm_i = {{(XLEN-12){inst[31]}}, inst[31:20]};
  assign imm_s = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
  assign imm_j = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

  always_comb begin
    dec          = '0;
    legal        = 1'b1;
    dec.pc       = inst_pc;
    dec.funct3   = f3;
    dec.funct7b5 = inst[30];
    dec.rd       = inst[11:7];
    dec.rs1      = inst[19:15];
    dec.rs2      = inst[24:20];
    dec.op       = OP_ILLEGAL;
    case (inst[6:0])
      7'h37: begin dec.op = OP_LUI;   dec.imm = imm_u; end
      7'h17: begin dec.op = OP_AUIPC; dec.imm = imm_u; end
      7'h6F: begin dec.op = OP_JAL;   dec.imm = imm_j; end
      7'h67: begin dec.op = OP_JALR;  dec.imm = imm_i; legal = (f3 == 3'd0); end
      7'h63: begin
        dec.op = OP_BRANCH; dec.imm = imm_b;
        legal  = (f3 != 3'd2) && (f3 != 3'd3);
      end
      7'h03: begin
        dec.op = OP_LOAD; dec.imm = imm_i;
        legal  = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
      end
      7'h23: begin dec.op = OP_STORE; dec.imm = imm_s; legal = (f3 <= 3'd2); end
      7'h13: begin
        dec.op = OP_OPIMM; dec.imm = imm_i;
        // shift-immediates reuse the funct7 slot; other funct3 values are plain imm
        if (f3 == 3'd1)      legal = (f7 == 7'h00);
        else if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
      end
      7'h33: begin
        dec.op = OP_OP;
        legal  = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
      end
      7'h0F: dec.op = OP_FENCE;
      7'h73: begin dec.op = OP_SYSTEM; dec.imm = imm_i; end
      default: legal = 1'b0;
    endcase

    if ((dec.op == OP_BRANCH) || (dec.op == OP_STORE)) dec.rd = '0;
    if ((dec.op != OP_BRANCH) && (dec.op != OP_STORE) && (dec.op != OP_OP)) dec.rs2 = '0;
    if ((dec.op == OP_LUI) || (dec.op == OP_AUIPC) || (dec.op == OP_JAL)) dec.rs1 = '0;

    if (!legal || (inst[1:0] != 2'b11)) begin
      dec.op  = OP_ILLEGAL;
      dec.rd  = '0;
      dec.rs1 = '0;
      dec.rs2 = '0;
      dec.imm = '0;
    end
    dec.illegal = (dec.op == OP_ILLEGAL);
  end

  bundle_t out_q, out_d;
  logic    ex_valid_q, ex_valid_d;
  logic    out_free, accept;

  assign out_free = !ex_valid_q || ex_ready;
  assign accept   = inst_valid && id_ready && !wb_pc_valid;

`ifdef MR_ID_SKID_EN
  bundle_t skid_q, skid_d;
  logic    skid_valid_q, skid_valid_d;

  assign id_ready = !skid_valid_q;

  always_comb begin
    out_d        = out_q;
    ex_valid_d   = ex_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (wb_pc_valid) begin
      ex_valid_d   = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      // a full skid entry blocks accept, so it is always the oldest word
      if (skid_valid_q) begin
        out_d        = skid_q;
        ex_valid_d   = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_d      = accept ? dec : out_q;
        ex_valid_d = accept;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end
`else
  assign id_ready = out_free;

  always_comb begin
    out_d      = out_q;
    ex_valid_d = ex_valid_q;
    if (wb_pc_valid) begin
      ex_valid_d = 1'b0;
    end else if (accept) begin
      out_d      = dec;
      ex_valid_d = 1'b1;
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q      <= '0;
      ex_valid_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      ex_valid_q <= ex_valid_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_pc       = out_q.pc;
  assign ex_op       = out_q.op;
  assign ex_rd       = out_q.rd;
  assign ex_rs1      = out_q.rs1;
  assign ex_rs2      = out_q.rs2;
  assign ex_imm      = out_q.imm;
  assign ex_funct3   = out_q.funct3;
  assign ex_funct7b5 = out_q.funct7b5;
  assign ex_illegal  = out_q.illegal;

endmodule

// File: doc/mr_idecode.md
Name: mr_idecode

Overview:
- Instruction decode stage, directly downstream of the fetch stage.
- Accepts fetched instruction words with their PC over a valid/ready handshake.
- Decodes RV32I base-ISA fields into a registered bundle for the execute stage: op class, register indices, sign-extended immediate, funct bits and an illegal flag.
- Handles EX backpressure and flushes in-flight work on a writeback PC redirect.

Parameters:
- XLEN, 32, datapath width; must equal `XLEN.
- IMAXLEN, 32, instruction word width; must equal `IMAXLEN.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- inst  in  IMAXLEN  instruction word from fetch.
- inst_pc  in  XLEN  PC of inst.
- inst_valid  in  1  inst/inst_pc valid this cycle.
- id_ready  out  1  decode accepts inst this cycle.
- wb_pc_valid  in  1  redirect/flush from writeback.
- ex_valid  out  1  decoded bundle valid.
- ex_ready  in  1  EX accepts bundle.
- ex_pc  out  XLEN  PC of decoded instruction.
- ex_op  out  4  op class.
- ex_rd  out  5  destination register.
- ex_rs1  out  5  source register 1.
- ex_rs2  out  5  source register 2.
- ex_imm  out  XLEN  sign-extended immediate.
- ex_funct3  out  3  inst[14:12].
- ex_funct7b5  out  1  inst[30].
- ex_illegal  out  1  illegal-instruction flag.

Behaviour:
- Reset (rst=0, async): ex_valid=0 and all ex_* data outputs =0. id_ready follows its combinational rule below (no skid) or resets to 1 (skid).
- Transfer into ID occurs when inst_valid & id_ready. Transfer out to EX occurs when ex_valid & ex_ready.
- Latency: one cycle. A word accepted at edge N appears on ex_* after edge N.
- Without skid: id_ready = !ex_valid | ex_ready (combinational).
- ex_* outputs hold stable while ex_valid & !ex_ready.
- Op classes:
  - LUI=0, AUIPC=1, JAL=2, JALR=3, BRANCH=4, LOAD=5, STORE=6, OPIMM=7, OP=8, FENCE=9, SYSTEM=10.
  - Values 11-14 are reserved.
  - ILLEGAL=15, and ex_illegal=1 whenever ex_op=15.
- Immediates (always sign-extended from inst[31]):
  - I-type: JALR, LOAD, OPIMM, SYSTEM.
  - S-type: STORE.
  - B-type: BRANCH, bit0=0.
  - U-type: LUI, AUIPC; low 12 bits =0.
  - J-type: JAL, bit0=0.
  - OP and FENCE: imm=0.
- rd forced to 0 for BRANCH and STORE.
- rs2 forced to 0 for all classes except BRANCH, STORE and OP.
- rs1 forced to 0 for LUI, AUIPC and JAL.
- Illegal conditions:
  - inst[1:0] != 2'b11.
  - Unlisted opcode.
  - JALR with funct3 != 0.
  - BRANCH with funct3 = 2 or 3.
  - LOAD with funct3 = 3, 6 or 7.
  - STORE with funct3 > 2.
  - OP with funct7 not 0x00, or not 0x20 when funct3 is 0 or 5.
  - OPIMM shift where funct3=1 needs funct7=0x00, and funct3=5 needs funct7 of 0x00 or 0x20.
- Illegal instructions are still passed down with ex_valid=1; EX traps.
- Flush: wb_pc_valid=1 at edge makes ex_valid<=0 and empties any skid entry. An instruction presented in the same cycle is dropped, even if id_ready=1.
- Flush has priority over simultaneous accept/consume.
- Simultaneous consume and accept with a full output register: the new bundle replaces the old one with no bubble.

Optional Feature:
- Macro MR_ID_SKID_EN.
- Defined:
  - One-entry skid buffer added; id_ready is registered, equal to skid-empty, with no combinational path from ex_ready.
  - A word arriving while the output is stalled goes into the skid entry.
  - The skid entry drains into the output register on the next ex_ready, preserving order.
  - Throughput stays 1/cycle.
- Undefined: no skid; id_ready is combinational as above.

Test Plan:
- Decode, inst=0x123452B7 pc=0x80000000 with ex_ready=1 -> next cycle:
  - ex_valid=1, ex_op=0, ex_rd=5, ex_imm=0x12345000, ex_pc=0x80000000, ex_illegal=0.
- ADDI, inst=0xFFF00093 -> ex_op=7, ex_rd=1, ex_rs1=0, ex_imm=0xFFFFFFFF.
- BEQ, inst=0xFE208EE3 -> ex_op=4, ex_rs1=1, ex_rs2=2, ex_rd=0, ex_imm=0xFFFFFFFC, ex_funct3=0.
- Illegal, inst=0x00000000 -> ex_op=15 with ex_illegal=1 and ex_valid=1.
- Backpressure, ex_ready=0 for 3 cycles during a stream of 4 instructions:
  - ex_* stay stable.
  - No instruction is lost or duplicated.
  - Order is preserved, in both macro settings.
- Flush, wb_pc_valid=1 with ex_valid=1 and inst_valid=1:
  - Next cycle ex_valid=0.
  - The dropped instruction never appears.
  - The following accepted instruction decodes normally.
  - rst asserted mid-stream gives ex_valid=0 immediately (async).
